// File: rtl/mem_dump_reader.sv
// Read-side dump engine: sweeps COUNT words from BASE through a registered 1-cycle RAM port and
// streams them on valid/ready with a running XOR checksum. Never touches the RAM write port.
module mem_dump_reader #(
  parameter int WID_MEM   = 8,
  parameter int DEPTH_MEM = 2048,
  parameter int CNT_W     = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   base_addr_i,
  input  logic [CNT_W-1:0]   count_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WID_MEM-1:0] checksum_o,
  output logic [31:0]        mem_raddr_o,
  input  logic [WID_MEM-1:0] mem_dout_i,
  output logic [WID_MEM-1:0] m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               m_last_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_MEM - 1);

  state_t             state_q, state_d;
  logic [31:0]        mem_raddr_q, mem_raddr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic               primed_q, primed_d;
  logic               inflight_q, inflight_d;
  logic [WID_MEM-1:0] fifo0_q, fifo0_d;
  logic [WID_MEM-1:0] fifo1_q, fifo1_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         occ_q, occ_d;
  logic [WID_MEM-1:0] checksum_q, checksum_d;

  logic [31:0]        base_mod;
  logic [31:0]        raddr_next;
  logic [CNT_W-1:0]   issued_inc;
  logic [WID_MEM-1:0] head;
  logic               valid;
  logic               last;
  logic               hs;
  logic               credit_ok;
  logic               rd_issue;

  assign base_mod   = 32'(base_addr_i % CNT_W'(DEPTH_MEM));
  assign raddr_next = (mem_raddr_q == LAST_ADDR) ? 32'd0 : mem_raddr_q + 32'd1;
  assign issued_inc = issued_q + CNT_W'(1);
  assign head       = rd_ptr_q ? fifo1_q : fifo0_q;
  assign valid      = (occ_q != 2'd0);
  assign last       = valid && (beats_q == count_q - CNT_W'(1));
  assign hs         = valid && m_ready_i;
  // A read may only go out if its word is guaranteed a FIFO slot when it lands.
  assign credit_ok  = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, hs});
  assign rd_issue   = (state_q == S_RUN) && primed_q && credit_ok;

  always_comb begin
    state_d     = state_q;
    mem_raddr_d = mem_raddr_q;
    count_d     = count_q;
    issued_d    = issued_q;
    beats_d     = beats_q;
    primed_d    = primed_q;
    inflight_d  = rd_issue;
    fifo0_d     = fifo0_q;
    fifo1_d     = fifo1_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    checksum_d  = checksum_q;
    occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, hs};

    if (inflight_q) begin
      if (wr_ptr_q) fifo1_d = mem_dout_i;
      else          fifo0_d = mem_dout_i;
      wr_ptr_d = ~wr_ptr_q;
    end

    if (hs) begin
      rd_ptr_d   = ~rd_ptr_q;
      beats_d    = beats_q + CNT_W'(1);
      checksum_d = checksum_q ^ head;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          count_d    = count_i;
          issued_d   = '0;
          beats_d    = '0;
          checksum_d = '0;
          primed_d   = 1'b0;
          if (count_i == '0) begin
            state_d = S_FIN;
          end else begin
            state_d     = S_RUN;
            mem_raddr_d = base_mod;
          end
        end
      end
      S_RUN: begin
        // One settle cycle after acceptance places the first beat at E0+3.
        primed_d = 1'b1;
        if (rd_issue) begin
          issued_d    = issued_inc;
          mem_raddr_d = raddr_next;
          if (issued_inc == count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs && last) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      mem_raddr_q <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      beats_q     <= '0;
      primed_q    <= 1'b0;
      inflight_q  <= 1'b0;
      fifo0_q     <= '0;
      fifo1_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_raddr_q <= mem_raddr_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      beats_q     <= beats_d;
      primed_q    <= primed_d;
      inflight_q  <= inflight_d;
      fifo0_q     <= fifo0_d;
      fifo1_q     <= fifo1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      checksum_q  <= checksum_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FIN);
  assign checksum_o  = checksum_q;
  assign mem_raddr_o = mem_raddr_q;
  assign m_valid_o   = valid;
  assign m_data_o    = valid ? head : '0;
  assign m_last_o    = last;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: 16-word RAM model preloaded with 8'h10+i, directed and random dumps
// checked against an expected-word queue built from the RAM contents.
module tb_mem_dump_reader;
  localparam int WID   = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [CW-1:0]   base_addr;
  logic [CW-1:0]   count;
  logic            busy;
  logic            done;
  logic [WID-1:0]  checksum;
  logic [31:0]     mem_raddr;
  logic [WID-1:0]  mem_dout;
  logic [WID-1:0]  m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;

  logic [WID-1:0]  ram [DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= ram[mem_raddr[3:0]];

  mem_dump_reader #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .base_addr_i (base_addr),
    .count_i     (count),
    .busy_o      (busy),
    .done_o      (done),
    .checksum_o  (checksum),
    .mem_raddr_o (mem_raddr),
    .mem_dout_i  (mem_dout),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_last_o    (m_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic pick_ready(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return ((n - 1) % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // poke_n > 0 raises start (base 9, count 3) for one cycle at that negedge of the job.
  task automatic run_job(input int b, input int c, input int mode, input int poke_n);
    logic [WID-1:0] exp_q[$];
    logic [WID-1:0] exp_sum = '0;
    logic [WID-1:0] stall_data = '0;
    logic           stall_last = 1'b0;
    logic           stall = 1'b0;
    logic           rdy;
    int n = 0, first_n = -1, done_n = -1, last_hs_n = -1, got = 0;
    int busy_bad = 0, stable_bad = 0, extra = 0, ahead_max = 0, a, exp_done;

    for (int k = 0; k < c; k++) begin
      exp_q.push_back(ram[(b + k) % DEPTH]);
      exp_sum ^= ram[(b + k) % DEPTH];
    end

    @(negedge clk);
    start = 1'b1; base_addr = 32'(b); count = 32'(c); m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    while (done_n < 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (poke_n > 0 && n == poke_n) begin
        start = 1'b1; base_addr = 32'd9; count = 32'd3;
      end else if (poke_n > 0 && n == poke_n + 1) begin
        start = 1'b0;
      end
      rdy = pick_ready(mode, n);
      m_ready = rdy;
      if (!busy) busy_bad++;
      if (c > 0 && c < DEPTH) begin
        a = int'((mem_raddr - 32'(b)) & 32'(DEPTH - 1)) - got;
        if (a > ahead_max) ahead_max = a;
      end
      if (stall && (!m_valid || m_data !== stall_data || m_last !== stall_last)) stable_bad++;
      if (m_valid && first_n < 0) first_n = n;
      if (m_valid && rdy) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          check("beat_data", 32'(m_data), 32'(exp_q[0]));
          check("beat_last", 32'(m_last), (exp_q.size() == 1) ? 32'd1 : 32'd0);
          void'(exp_q.pop_front());
          got++;
          if (got == c) last_hs_n = n;
        end
      end
      stall = m_valid && !rdy;
      stall_data = m_data;
      stall_last = m_last;
      if (done) done_n = n;
    end

    exp_done = (c == 0) ? 1 : last_hs_n + 1;
    check("done_time", 32'(done_n), 32'(exp_done));
    check("beats", 32'(got), 32'(c));
    check("extra_beats", 32'(extra), 32'd0);
    check("checksum", 32'(checksum), 32'(exp_sum));
    check("busy_during", 32'(busy_bad), 32'd0);
    check("stall_stable", 32'(stable_bad), 32'd0);
    if (c == 0) check("no_valid", 32'(first_n), 32'hFFFF_FFFF);
    if (c > 0 && c < DEPTH) check("raddr_ahead", 32'(ahead_max <= 2), 32'd1);
    if (mode == 0 && c > 0) begin
      check("first_lat", 32'(first_n), 32'd4);
      check("done_lat", 32'(done_n), 32'(c + 4));
    end

    @(negedge clk);
    start = 1'b0;
    m_ready = 1'b1;
    check("busy_after", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
    check("sum_hold", 32'(checksum), 32'(exp_sum));
  endtask

  task automatic reset_mid_job();
    int got = 0, n = 0, bad = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 32'd3; count = 32'd8; m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (got < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (m_valid && m_ready) got++;
    end
    check("rst_pre_beats", 32'(got), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(checksum), 32'd0);
    check("rst_raddr", mem_raddr, 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || m_valid) bad++;
    end
    check("rst_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(8'h10 + i);
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_busy", 32'(busy), 32'd0);
    check("init_done", 32'(done), 32'd0);
    check("init_sum", 32'(checksum), 32'd0);
    check("init_raddr", mem_raddr, 32'd0);
    check("init_valid", 32'(m_valid), 32'd0);
    check("init_last", 32'(m_last), 32'd0);
    check("init_data", 32'(m_data), 32'd0);
    reset = 1'b0;

    run_job(2, 4, 0, 0);
    check("sum_2_4", 32'(checksum), 32'h00);
    run_job(14, 4, 0, 0);
    check("sum_14_4", 32'(checksum), 32'h00);
    run_job(0, 8, 1, 0);
    run_job(0, 0, 0, 0);
    run_job(0, 0, 0, 1);
    run_job(5, 6, 0, 2);
    reset_mid_job();
    run_job(7, 5, 0, 0);
    run_job(11, 20, 3, 0);

    for (int j = 0; j < 20; j++) begin
      run_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 3)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
